// File: rtl/multiword_add_seq.sv
// Sequential WORDS x 16-bit adder reusing one 16-bit lookahead_adder, one slice per cycle; `define SUBTRACT_EN adds sub port.
// Latency: WORDS+1 cycles from accepted start to the one-cycle done pulse; throughput one op per WORDS+2 cycles.
// Backpressure: start is accepted only while busy=0; requests in RUN/DONE are dropped, no queueing.

module lookahead_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        pg,
    output logic        gg
);
    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  bp;
    logic [3:0]  bg;
    logic [4:0]  bc;
    logic [16:0] c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        bp = '0;
        bg = '0;
        bc = '0;
        c  = '0;
        for (int i = 0; i < 4; i++) begin
            bp[i] = &p[4*i +: 4];
            bg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        end
        // group carries from block generate/propagate, then bit carries inside each block
        bc[0] = cin;
        for (int i = 0; i < 4; i++) begin
            bc[i+1] = bg[i] | (bp[i] & bc[i]);
        end
        for (int i = 0; i < 4; i++) begin
            c[4*i] = bc[i];
            for (int j = 0; j < 3; j++) begin
                c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
            end
        end
        c[16] = bc[4];
    end

    assign sum  = p ^ c[15:0];
    assign cout = c[16];
    assign pg   = &bp;
    assign gg   = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1]) | (bp[3] & bp[2] & bp[1] & bg[0]);
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef SUBTRACT_EN
    input  logic                  sub,
`endif
    input  logic                  cin,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    output logic [16*WORDS-1:0]   s,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                  state, state_nxt;
    logic [WORDS-1:0][15:0]  a_reg;
    logic [WORDS-1:0][15:0]  b_reg;
    logic [WORDS-1:0][15:0]  s_reg;
    logic                    carry_reg;
    logic [KW-1:0]           k;
    logic                    load;
    logic                    step;
    logic                    last;

    logic [15:0] a_slice;
    logic [15:0] b_slice;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        add_pg_unused;
    logic        add_gg_unused;

    logic        sub_sel;
`ifdef SUBTRACT_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign a_slice = a_reg[k];
    assign b_slice = b_reg[k];

    lookahead_adder u_add (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout),
        .pg   (add_pg_unused),
        .gg   (add_gg_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (k == LAST) begin
                    last      = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (load) begin
            a_reg     <= a;
            b_reg     <= sub_sel ? ~b : b;
            carry_reg <= sub_sel ? 1'b1 : cin;
            k         <= '0;
        end else if (step) begin
            s_reg[k]  <= add_sum;
            carry_reg <= add_cout;
            if (last) begin
                // k parks on the top slice so it never wraps back into slice 0
                cout <= add_cout;
                ovf  <= (a_slice[15] == b_slice[15]) & (add_sum[15] != a_slice[15]);
            end else begin
                k <= k + KW'(1);
            end
        end
    end

    assign s = s_reg;
endmodule
